// File: rtl/sw_sweep_controller_if.sv
// Bundle between the sweep controller, the switch datapath it drives, and the
// consumer of captured samples.
interface sw_sweep_controller_if #(
  parameter int WIDTH  = 7,
  parameter int CSUM_W = 16
);
  logic              start;
  logic [WIDTH-1:0]  sw;
  logic              sel;
  logic [WIDTH-1:0]  led;
  // A sample transfers on every rising clk edge where out_valid && out_ready.
  // While out_valid is high and out_ready low, every out_* field holds steady;
  // out_valid never drops without a transfer, and out_ready alone does nothing.
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [WIDTH-1:0]  out_sw;
  logic              out_sel;
  logic [7:0]        out_step;
  logic              busy;
  logic              done;
  logic [CSUM_W-1:0] checksum;

  modport master (
    input  start, led, out_ready,
    output sw, sel, out_valid, out_data, out_sw, out_sel, out_step,
           busy, done, checksum
  );

  modport slave (
    output start, led, out_ready,
    input  sw, sel, out_valid, out_data, out_sw, out_sel, out_step,
           busy, done, checksum
  );
endinterface

// File: rtl/sw_sweep_controller.sv
// Hardware sweep of the sw/sel -> led datapath: a count phase, then a
// shift-in-ones phase, each step captured after a settle delay and checksummed.
module sw_sweep_controller #(
  parameter int WIDTH     = 7,
  parameter int COUNT_LEN = 8,
  parameter int SETTLE    = 1,
  parameter int CSUM_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sw_sweep_controller_if.master bus,
  output logic [1:0]            dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int               CNT_W      = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [WIDTH-1:0] LAST_COUNT = WIDTH'(COUNT_LEN - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sw_q, sw_d;
  logic              sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        step_q, step_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [WIDTH-1:0]  out_sw_q, out_sw_d;
  logic              out_sel_q, out_sel_d;
  logic [7:0]        out_step_q, out_step_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CSUM_W-1:0] csum_q, csum_d;

  always_comb begin
    state_d     = state_q;
    sw_d        = sw_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    step_d      = step_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sw_d    = out_sw_q;
    out_sel_d   = out_sel_q;
    out_step_d  = out_step_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    csum_d      = csum_q;
    case (state_q)
      S_IDLE: begin
        sw_d   = '0;
        sel_d  = 1'b0;
        busy_d = 1'b0;
        if (bus.start) begin
          step_d  = '0;
          cnt_d   = CNT_LOAD;
          csum_d  = '0;
          busy_d  = 1'b1;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // Counter value 1 here means this edge is the SETTLE-th since sw moved.
        if (cnt_q == CNT_ONE) begin
          out_data_d  = bus.led;
          out_sw_d    = sw_q;
          out_sel_d   = sel_q;
          out_step_d  = step_q;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          csum_d      = csum_q + CSUM_W'(out_data_q);
          if (sel_q && (&sw_q)) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            if (!sel_q) begin
              if (sw_q == LAST_COUNT) begin
                sel_d = 1'b1;
                sw_d  = '0;
              end else begin
                sw_d = sw_q + WIDTH'(1);
              end
            end else begin
              sw_d = (sw_q << 1) | WIDTH'(1);
            end
            step_d  = step_q + 8'd1;
            cnt_d   = CNT_LOAD;
            state_d = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        sw_d    = '0;
        sel_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sw_q        <= '0;
      sel_q       <= 1'b0;
      cnt_q       <= '0;
      step_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sw_q    <= '0;
      out_sel_q   <= 1'b0;
      out_step_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      csum_q      <= '0;
    end else begin
      state_q     <= state_d;
      sw_q        <= sw_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sw_q    <= out_sw_d;
      out_sel_q   <= out_sel_d;
      out_step_q  <= out_step_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      csum_q      <= csum_d;
    end
  end

  assign bus.sw        = sw_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sw    = out_sw_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_step  = out_step_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.checksum  = csum_q;
  assign dbg_state     = state_q;
endmodule
